// File: rtl/lib_cpu_pkg.sv
// Shared definitions for the TD4 CPU core: execution modes, controller
// states and a counter-width helper.
package lib_cpu;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_SLOW   = 2'd1,
    MODE_FAST   = 2'd2,
    MODE_FULL   = 2'd3
  } step_mode_e;

  // Encoding 3 is unused and treated as an illegal state.
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } ctrl_state_e;

  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/td4_step_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level filter and a
// single-cycle pulse on each accepted rising level.
module btn_debounce
  import lib_cpu::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  localparam int               CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], btn_in};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_level & ~r_level_d;

endmodule

// File: rtl/td4_step_ctrl.sv
// TD4 execution controller: turns button presses, mode and breakpoint
// settings into the one-cycle instruction commit enable cpu_en.
module td4_step_ctrl
  import lib_cpu::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int SLOW_HZ         = 1,
  parameter int FAST_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       halt_req,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  input  logic [3:0] ip,
  output logic       cpu_en,
  output logic       halted,
  output logic [1:0] state
);

  localparam int            DIV_SLOW  = CLK_HZ / SLOW_HZ;
  localparam int            DIV_FAST  = CLK_HZ / FAST_HZ;
  localparam int            PW        = cnt_width((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST);
  localparam logic [PW-1:0] LAST_SLOW = PW'(DIV_SLOW - 1);
  localparam logic [PW-1:0] LAST_FAST = PW'(DIV_FAST - 1);

  ctrl_state_e   r_state;
  logic [PW-1:0] r_presc;
  logic          r_bp_skip;

  step_mode_e w_mode;
  logic       w_run_p;
  logic       w_step_p;
  logic       w_tick;
  logic       w_stop;
  logic       w_bp_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (run_btn),
    .press  (w_run_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (step_btn),
    .press  (w_step_p)
  );

  assign w_mode = step_mode_e'(mode);

  // NOTE: the default assignment before the case keeps w_tick from
  // inferring a latch for modes that do not set it.
  always_comb begin
    w_tick = 1'b0;
    case (w_mode)
      MODE_SLOW: w_tick = (r_presc >= LAST_SLOW);
      MODE_FAST: w_tick = (r_presc >= LAST_FAST);
      MODE_FULL: w_tick = 1'b1;
      default:   w_tick = 1'b0;
    endcase
  end

  // Leaving RUN for any of these reasons suppresses the commit in that cycle.
  assign w_stop   = halt_req | w_run_p | (w_mode == MODE_MANUAL);
  assign w_bp_hit = bp_en & (ip == bp_addr) & ~r_bp_skip;

  assign cpu_en = (r_state == ST_STEP) |
                  ((r_state == ST_RUN) & w_tick & ~w_stop & ~w_bp_hit);
  assign halted = (r_state == ST_HALT);
  assign state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HALT;
      r_presc   <= '0;
      r_bp_skip <= 1'b1;
    end else begin
      if ((r_state != ST_RUN) || w_tick) r_presc <= '0;
      else                               r_presc <= r_presc + 1'b1;

      case (r_state)
        ST_HALT: begin
          if (w_step_p) begin
            r_state <= ST_STEP;
          end else if (w_run_p && (w_mode != MODE_MANUAL) && !halt_req) begin
            r_state   <= ST_RUN;
            r_bp_skip <= 1'b1;
          end
        end
        ST_STEP: r_state <= ST_HALT;
        ST_RUN: begin
          if (w_stop || w_bp_hit) r_state   <= ST_HALT;
          else if (w_tick)        r_bp_skip <= 1'b0;
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_step_ctrl.sv
// Randomised self-checking bench for td4_step_ctrl; expected commit times
// come from the entry/stop cycles and the prescaler divide ratio.
module tb_td4_step_ctrl;

  localparam int CLK_HZ   = 100;
  localparam int SLOW_HZ  = 1;
  localparam int FAST_HZ  = 10;
  localparam int DEB      = 4;
  localparam int PRESS_LAT = 2 + DEB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       run_btn, step_btn, halt_req, bp_en;
  logic [3:0] bp_addr, ip, ip_base;
  logic       cpu_en, halted;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_commit = 0;
  int pulse_q[$];
  bit seen_run;

  td4_step_ctrl #(
    .CLK_HZ(CLK_HZ), .SLOW_HZ(SLOW_HZ), .FAST_HZ(FAST_HZ), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .run_btn(run_btn), .step_btn(step_btn),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .ip(ip),
    .cpu_en(cpu_en), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // Cycle index and a tiny CPU model: ip advances once per committed pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && cpu_en) n_commit <= n_commit + 1;
  end
  assign ip = ip_base + n_commit[3:0];

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_en) pulse_q.push_back(cyc);
      if (state == 2'd1) seen_run = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) cycle();
  endtask

  task automatic do_press(input bit r, input bit s, input int hold, output int t);
    run_btn  = r;
    step_btn = s;
    t        = cyc;
    repeat (hold) cycle();
    run_btn  = 1'b0;
    step_btn = 1'b0;
  endtask

  // Running for cycles [entry, stop): a commit lands in every DIV-th cycle.
  task automatic check_pulses(input string tag, input int entry, input int div,
                              input int stop, output int n);
    int exp_q[$];
    for (int p = entry + div - 1; p < stop; p += div) exp_q.push_back(p);
    n = exp_q.size();
    check({tag, "_count"}, pulse_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < pulse_q.size(); k++)
      check({tag, "_at"}, pulse_q[k], exp_q[k]);
    pulse_q.delete();
  endtask

  function automatic int div_of(input logic [1:0] m);
    return (m == 2'd1) ? CLK_HZ / SLOW_HZ : (m == 2'd2) ? CLK_HZ / FAST_HZ : 1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, entry, stop, len, n, ip0, bp;
    bit by_req;
    rst_n = 1'b0; mode = 2'd0; run_btn = 1'b0; step_btn = 1'b0;
    halt_req = 1'b0; bp_en = 1'b0; bp_addr = 4'd0; ip_base = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halted", halted, 1);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_state", state, 0);
    rst_n = 1'b1;
    cycle();

    // Manual single step.
    pulse_q.delete();
    do_press(1'b0, 1'b1, 8, t);
    repeat (15) cycle();
    check("step_state", state, 0);
    check_pulses("step", t + PRESS_LAT, 1, t + PRESS_LAT + 1, n);

    // A 3-cycle glitch on run must be filtered.
    mode = 2'd2; seen_run = 1'b0;
    do_press(1'b1, 1'b0, 3, t);
    repeat (15) cycle();
    check("glitch_state", state, 0);
    check("glitch_run", seen_run, 0);
    check_pulses("glitch", t, 1, t, n);

    // Run and step together: step wins.
    seen_run = 1'b0;
    do_press(1'b1, 1'b1, 5, t);
    repeat (20) cycle();
    check("both_run", seen_run, 0);
    check("both_state", state, 0);
    check_pulses("both", t + PRESS_LAT, 1, t + PRESS_LAT + 1, n);

    // Randomised runs in each speed, stopped by halt_req or a run press.
    for (int i = 0; i < 6; i++) begin
      mode   = 2'((i % 3) + 1);
      by_req = (i == 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
      len    = $urandom_range(15, 250);
      pulse_q.delete();
      do_press(1'b1, 1'b0, 5, t);
      wait_until(t + PRESS_LAT - 1);
      check("entry_early", state, 0);
      wait_until(t + PRESS_LAT);
      check("entry", state, 1);
      entry = t + PRESS_LAT;
      wait_until(entry + len);
      if (by_req) begin
        halt_req = 1'b1;
        #1;
        check("halt_req_cpu_en", cpu_en, 0);
        stop = entry + len;
        cycle();
        check("halt_req_state", state, 0);
        halt_req = 1'b0;
      end else begin
        do_press(1'b1, 1'b0, 5, t2);
        stop = t2 + PRESS_LAT - 1;
        wait_until(stop);
        check("run_stop_last", state, 1);
        wait_until(stop + 1);
        check("run_stop_state", state, 0);
      end
      repeat (20) cycle();
      check_pulses($sformatf("run%0d", i), entry, div_of(mode), stop, n);
    end

    // Switching to manual while running halts on the next cycle.
    mode = 2'd2;
    pulse_q.delete();
    do_press(1'b1, 1'b0, 5, t);
    entry = t + PRESS_LAT;
    wait_until(entry + 25);
    mode = 2'd0;
    cycle();
    check("mode0_state", state, 0);
    mode = 2'd2;
    repeat (20) cycle();
    check_pulses("mode0", entry, 10, entry + 25, n);

    // Breakpoint: stop before executing bp, then resume through it.
    ip0 = $urandom_range(0, 8);
    bp  = ip0 + $urandom_range(1, 3);
    ip_base = 4'(ip0) - n_commit[3:0];
    bp_addr = 4'(bp);
    bp_en   = 1'b1;
    pulse_q.delete();
    do_press(1'b1, 1'b0, 5, t);
    entry = t + PRESS_LAT;
    stop  = entry + (bp - ip0) * 10;
    wait_until(stop);
    check("bp_ip", ip, bp);
    check("bp_cpu_en", cpu_en, 0);
    wait_until(stop + 1);
    check("bp_state", state, 0);
    repeat (15) cycle();
    check_pulses("bp", entry, 10, stop, n);
    check("bp_ip_held", ip, bp);

    do_press(1'b1, 1'b0, 5, t);
    entry = t + PRESS_LAT;
    wait_until(entry + 9);
    check("resume_ip", ip, bp);
    check("resume_cpu_en", cpu_en, 1);
    wait_until(entry + 35);
    do_press(1'b1, 1'b0, 5, t2);
    stop = t2 + PRESS_LAT - 1;
    wait_until(stop + 1);
    check("resume_state", state, 0);
    repeat (20) cycle();
    check_pulses("resume", entry, 10, stop, n);
    check("resume_ip_end", ip, (bp + n) & 15);
    bp_en = 1'b0;

    // Reset asserted mid-run drops everything immediately.
    mode = 2'd3;
    do_press(1'b1, 1'b0, 5, t);
    wait_until(t + PRESS_LAT + 3);
    check("pre_rst_cpu_en", cpu_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_halted", halted, 1);
    check("mid_rst_cpu_en", cpu_en, 0);
    check("mid_rst_state", state, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/td4_step_ctrl.md
Name: td4_step_ctrl

Overview:
- Execution controller for the 4-bit TD4 CPU core.
- Generates the single-cycle CPU advance enable `cpu_en` from the board clock; `cpu_en` is consumed by the register write-back stage.
- Provides four modes: manual single-step, slow run, fast run and full-speed run.
- Halts on a run/stop button, an external halt request or an instruction-pointer breakpoint. Exposes halted status to the board LEDs.

Parameters:
- CLK_HZ, 50_000_000, board clock frequency.
- SLOW_HZ, 1, instruction rate in slow mode.
- FAST_HZ, 10, instruction rate in fast mode.
- DEBOUNCE_CYCLES, 500_000, cycles a button level must stay stable before it is accepted.

Ports:
- clk  in  1  board clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  execution mode: 00 manual, 01 slow, 10 fast, 11 full-speed. Static during operation.
- run_btn  in  1  raw run/stop button, asynchronous, active-high.
- step_btn  in  1  raw single-step button, asynchronous, active-high.
- halt_req  in  1  synchronous level request to stop.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  4  breakpoint instruction address.
- ip  in  4  current CPU instruction pointer.
- cpu_en  out  1  one-cycle pulse; the CPU commits exactly one instruction per pulse.
- halted  out  1  high in the HALT state.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset values: state=HALT, cpu_en=0, halted=1, prescaler=0, bp_skip=1, debouncer outputs 0.
- Reset is asynchronous assert; all flops clear immediately.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a stable-level counter.
  - A press is accepted once the level has been stable for DEBOUNCE_CYCLES cycles.
  - A press produces a single-cycle rising-edge pulse (run_p / step_p).
  - Total latency from the raw edge to the pulse is 2+DEBOUNCE_CYCLES+1 cycles.
- Prescaler:
  - DIV = CLK_HZ/SLOW_HZ in mode 01 and CLK_HZ/FAST_HZ in mode 10 (integer division).
  - The counter counts 0..DIV-1 and raises tick for one cycle on the wrap.
  - In mode 11, tick=1 every cycle.
  - The counter clears to 0 when entering RUN, so the first tick arrives DIV cycles after entry.
- FSM states:
  - HALT=0, RUN=1, STEP=2. Encoding 3 is illegal and recovers to HALT on the next clock.
  - HALT:
    - step_p → STEP.
    - Otherwise run_p with mode≠00 and halt_req=0 → RUN, and set bp_skip=1.
    - run_p in mode 00 is ignored.
  - STEP: cpu_en=1 for exactly this one cycle, then → HALT unconditionally. Breakpoints and halt_req are ignored here.
  - RUN: checks are evaluated in priority order each cycle.
    1. halt_req=1 or run_p → HALT. No cpu_en is issued that cycle.
    2. bp_en=1, ip==bp_addr and bp_skip=0 → HALT with no cpu_en, so the CPU stops before executing bp_addr.
    3. tick → cpu_en=1 and clear bp_skip.
  - bp_skip lets a resume from a breakpoint execute the breakpoint instruction once.
- Halt on mode change: a mode change to 00 while in RUN → HALT on the next cycle.
- Simultaneous events:
  - step_p and run_p together in HALT: step wins.
  - A step_p arriving while in RUN is dropped.
- Outputs: cpu_en is registered-free combinational from state and tick, glitch-free in the clk domain. halted = (state==HALT).
- Reset mid-pulse: cpu_en drops immediately and no partial instruction is committed.

Decomposition:
- Shared package lib_cpu gains:
  - STEP_MODE enum (MODE_MANUAL, MODE_SLOW, MODE_FAST, MODE_FULL).
  - CTRL_STATE enum (ST_HALT, ST_RUN, ST_STEP).
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_in, press), instantiated twice.
- The prescaler stays inline.

Test Plan (CLK_HZ=100, SLOW_HZ=1, FAST_HZ=10, DEBOUNCE_CYCLES=4):
- Reset: rst_n=0 → halted=1, cpu_en=0, state=0. Step press held 8 cycles after release → exactly one cpu_en pulse, 7 cycles after the raw edge; state returns to 0.
- Fast run: mode=10, run press → cpu_en pulses every 10 cycles, first pulse 10 cycles after entering RUN; a second run press → HALT with no further pulses.
- Full-speed run: mode=11, run → cpu_en=1 every cycle. halt_req=1 → cpu_en=0 that same cycle and state=HALT next.
- Breakpoint and resume:
  - bp_en=1, bp_addr=5, ip stepping 3,4,5 in fast mode → halt with ip=5 and no pulse at ip=5.
  - Run again → one pulse executes address 5, then normal running continues.
- Button glitch: a 3-cycle pulse on run_btn → no state change.
- Simultaneous presses: run and step pressed together in HALT → STEP only, one cpu_en pulse. Asserting rst_n=0 during RUN → immediate halted=1.
